// File: rtl/dmem_lat.sv
// dmem_lat: word-organised data memory with configurable access latency,
// byte-enable writes and a busy/done stall handshake for the Memory stage.
// LATENCY=0 gives a single-cycle combinational-read memory; LATENCY>=1 uses an
// IDLE/WAIT FSM that captures the request and completes it LATENCY cycles later.
// Optional feature macro: DMEM_ALIGN_CHECK_EN adds the err port, suppresses
// misaligned writes and returns zero for misaligned reads.
module dmem_lat #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        done,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        err,
`endif
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Storage is deliberately not reset.
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          mis;
  logic          unused_addr;

  assign idx = a[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis         = |a[1:0];
  assign unused_addr = ^a[31:AW+2];
`else
  assign mis         = 1'b0;
  assign unused_addr = ^{a[31:AW+2], a[1:0]};
`endif

  // Stall request to the hazard unit; forced low while in reset.
  assign busy = req & ~done & ~reset;

  if (LATENCY == 0) begin : g_comb

    // Single-cycle access: completion and read data follow req directly.
    always_comb begin
      done = req & ~reset;
      rd   = 32'h0;
      if (done && !mis) begin
        rd = mem[idx];
      end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign err = req & ~reset & mis;
`endif

    // Write commits on the edge ending the request cycle.
    always_ff @(posedge clk) begin
      if (req && we && !reset && !mis) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[idx][8*i +: 8] <= wd[8*i +: 8];
          end
        end
      end
    end

  end else begin : g_seq

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          accept;
    logic          we_q;
    logic [3:0]    be_q;
    logic [AW-1:0] idx_q;
    logic          mis_q;
    logic [31:0]   wd_q;

    // Control state; reset discards any access in flight.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= 4'h0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state, down-counter and completion decode.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      done    = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            accept  = 1'b1;
            cnt_d   = 4'(LATENCY - 1);
            state_d = StWait;
          end
        end
        StWait: begin
          if (cnt_q != 4'h0) begin
            cnt_d = cnt_q - 4'h1;
          end else begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Request capture; live inputs are ignored until the FSM is back in IDLE.
    always_ff @(posedge clk) begin
      if (accept) begin
        we_q  <= we;
        be_q  <= be;
        idx_q <= idx;
        mis_q <= mis;
        wd_q  <= wd;
      end
    end

    // Read data comes from the captured address and only during done.
    always_comb begin
      rd = 32'h0;
      if (done && !mis_q) begin
        rd = mem[idx_q];
      end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign err = done & mis_q;
`endif

    // Captured write commits on the edge ending the done cycle.
    always_ff @(posedge clk) begin
      if (done && we_q && !mis_q && !reset) begin
        for (int i = 0; i < 4; i++) begin
          if (be_q[i]) begin
            mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
          end
        end
      end
    end

  end

endmodule

// File: tb/tb_dmem_lat.sv
// Bench for dmem_lat: three instances (LATENCY 0, 3, 4; DEPTH 64) driven one
// access at a time. Read expectations come from a byte-lane memory model and
// are queued at stimulus time, then popped when the instance raises done.
module tb_dmem_lat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       req;
  logic [2:0]       we;
  logic [2:0]       done;
  logic [2:0]       busy;
  logic [2:0][3:0]  be;
  logic [2:0][31:0] a;
  logic [2:0][31:0] wd;
  logic [2:0][31:0] rd;
`ifdef DMEM_ALIGN_CHECK_EN
  logic [2:0]       err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model [3][64];
  logic [31:0] exp_q [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_lat #(
      .DEPTH   (64),
      .LATENCY ((g == 0) ? 0 : g + 2)
    ) u_dut (
      .clk   (clk),
      .reset (rst[g]),
      .req   (req[g]),
      .we    (we[g]),
      .be    (be[g]),
      .a     (a[g]),
      .wd    (wd[g]),
      .rd    (rd[g]),
      .done  (done[g]),
`ifdef DMEM_ALIGN_CHECK_EN
      .err   (err[g]),
`endif
      .busy  (busy[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : d + 2;
  endfunction

  // One access on instance d; req stays high afterwards so the next call is back-to-back.
  task automatic access(input int d, input logic w, input logic [3:0] b,
                        input logic [31:0] addr, input logic [31:0] data);
    int          cyc;
    logic        mis;
    logic [31:0] exp_rd;
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`endif
    if (!w) begin
      exp_q.push_back(mis ? 32'h0 : model[d][addr[7:2]]);
    end else if (!mis) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[d][addr[7:2]][8*i +: 8] = data[8*i +: 8];
      end
    end
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; a[d] = addr; wd[d] = data;
    cyc = 0;
    #1;
    while (done[d] !== 1'b1 && cyc < 20) begin
      n_checks++;
      if (busy[d] !== 1'b1)
        $display("FAIL busy_wait dut%0d cyc%0d: got %b want 1", d, cyc, busy[d]);
      else n_pass++;
      @(negedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (done[d] !== 1'b1 || cyc != lat_of(d))
      $display("FAIL latency dut%0d a=%h: done=%b after %0d cycles, want done=1 after %0d",
               d, addr, done[d], cyc, lat_of(d));
    else n_pass++;
    n_checks++;
    if (busy[d] !== 1'b0)
      $display("FAIL busy_done dut%0d a=%h: got %b want 0", d, addr, busy[d]);
    else n_pass++;
    if (!w) begin
      exp_rd = exp_q.pop_front();
      n_checks++;
      if (rd[d] !== exp_rd)
        $display("FAIL read dut%0d a=%h: got %h want %h", d, addr, rd[d], exp_rd);
      else n_pass++;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    n_checks++;
    if (err[d] !== mis)
      $display("FAIL err dut%0d a=%h: got %b want %b", d, addr, err[d], mis);
    else n_pass++;
`endif
  endtask

  // Drop req for one cycle; done/busy must both be low there.
  task automatic idle(input int d);
    @(negedge clk);
    req[d] = 1'b0; we[d] = 1'b0;
    #1;
    n_checks++;
    if (done[d] !== 1'b0 || busy[d] !== 1'b0)
      $display("FAIL idle dut%0d: done=%b busy=%b want 0 0", d, done[d], busy[d]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 3'b111; req = 3'b111; we = 3'b000;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (done[d] !== 1'b0 || busy[d] !== 1'b0 || rd[d] !== 32'h0)
        $display("FAIL reset dut%0d: done=%b busy=%b rd=%h want 0 0 0",
                 d, done[d], busy[d], rd[d]);
      else n_pass++;
    end
    req = 3'b000;
    @(negedge clk);
    rst = 3'b000;
  endtask

  task automatic test_lat0();
    access(0, 1'b1, 4'hF, 32'd100, 32'd25);
    access(0, 1'b0, 4'hF, 32'd100, 32'h0);
    idle(0);
  endtask

  task automatic test_back_to_back();
    access(1, 1'b1, 4'hF, 32'd8, 32'hDEAD_BEEF);
    access(1, 1'b0, 4'hF, 32'd8, 32'h0);
    access(1, 1'b0, 4'hF, 32'd8, 32'h0);
    idle(1);
  endtask

  task automatic test_byte_en();
    access(1, 1'b1, 4'hF, 32'd0, 32'h1122_3344);
    access(1, 1'b1, 4'b0101, 32'd0, 32'hAABB_CCDD);
    access(1, 1'b0, 4'hF, 32'd0, 32'h0);
    access(1, 1'b1, 4'b0000, 32'd0, 32'hFFFF_FFFF);
    access(1, 1'b0, 4'b0000, 32'd0, 32'h0);
    idle(1);
  endtask

  task automatic test_wrap();
    access(0, 1'b1, 4'hF, 32'h100, 32'd7);
    access(0, 1'b0, 4'hF, 32'h0, 32'h0);
    access(1, 1'b1, 4'hF, 32'hFFFF_FF0C, 32'h55);
    access(1, 1'b0, 4'hF, 32'h0C, 32'h0);
    idle(0);
    idle(1);
  endtask

  task automatic test_reset_mid();
    access(2, 1'b1, 4'hF, 32'd4, 32'd5);
    idle(2);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; a[2] = 32'd4; wd[2] = 32'd9;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (busy[2] !== 1'b1) $display("FAIL busy_pre_reset: got %b want 1", busy[2]);
    else n_pass++;
    rst[2] = 1'b1;
    #1;
    n_checks++;
    if (done[2] !== 1'b0 || busy[2] !== 1'b0)
      $display("FAIL reset_mid: done=%b busy=%b want 0 0", done[2], busy[2]);
    else n_pass++;
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    access(2, 1'b0, 4'hF, 32'd4, 32'h0);
    idle(2);
  endtask

  task automatic test_align();
    access(1, 1'b1, 4'hF, 32'd4, 32'h44);
    access(1, 1'b1, 4'hF, 32'd8, 32'h88);
    access(1, 1'b1, 4'hF, 32'd6, 32'hFFFF_FFFF);
    access(1, 1'b0, 4'hF, 32'd4, 32'h0);
    access(1, 1'b0, 4'hF, 32'd8, 32'h0);
    access(1, 1'b0, 4'hF, 32'd5, 32'h0);
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) access(d, 1'b1, 4'hF, 32'(k * 4), $urandom);
      for (int n = 0; n < 30; n++) begin
        addr = {$urandom_range(0, 255) << 8} | 32'($urandom_range(0, 15) * 4);
        access(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), addr, $urandom);
      end
      idle(d);
    end
  endtask

  initial begin
    req = '0; we = '0; be = '0; a = '0; wd = '0; rst = '1;
    test_reset();
    test_lat0();
    test_back_to_back();
    test_byte_en();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
